// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a 16 x 8 register memory.
// One access per cycle; every accepted request gets a registered response one cycle later.
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          IN_req_valid,
    input  logic [NUM_REQ-1:0]          IN_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   IN_req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]    IN_req_wdata,
    output logic [NUM_REQ-1:0]          OUT_req_ready,
    output logic [NUM_REQ-1:0]          OUT_rsp_valid,
    output logic [NUM_REQ*WIDTH-1:0]    OUT_rsp_rdata,
    output logic [NUM_REQ-1:0]          OUT_rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic               rr_ptr;

    logic [NUM_REQ-1:0] grant_p0;
    logic               sel_p0;
    logic               hs_p0;
    logic [ADDR_W-1:0]  addr_p0;
    logic               we_p0;
    logic [WIDTH-1:0]   wdata_p0;
    logic               in_range_p0;
    logic [IDX_W-1:0]   idx_p0;
    logic [WIDTH-1:0]   rdata_p0;

    logic [NUM_REQ-1:0]       rsp_vld_p1;
    logic [NUM_REQ*WIDTH-1:0] rsp_rdata_p1;
    logic [NUM_REQ-1:0]       rsp_err_p1;

    // Stage p0: arbitration, address check and memory access
    always_comb begin
        grant_p0 = '0;
        if (!rst) begin
            if (IN_req_valid[0] && IN_req_valid[1]) begin
                grant_p0[0] = !rr_ptr;
                grant_p0[1] = rr_ptr;
            end else begin
                grant_p0 = IN_req_valid;
            end
        end
    end

    always_comb begin
        sel_p0   = grant_p0[1];
        hs_p0    = |grant_p0;
        addr_p0  = sel_p0 ? IN_req_addr[2*ADDR_W-1:ADDR_W] : IN_req_addr[ADDR_W-1:0];
        we_p0    = sel_p0 ? IN_req_we[1] : IN_req_we[0];
        wdata_p0 = sel_p0 ? IN_req_wdata[2*WIDTH-1:WIDTH] : IN_req_wdata[WIDTH-1:0];
        // Full-width compare so high address bits cannot alias into the array
        in_range_p0 = addr_p0 < ADDR_W'(DEPTH);
        idx_p0      = addr_p0[IDX_W-1:0];
        rdata_p0    = (in_range_p0 && !we_p0) ? mem[idx_p0] : '0;
    end

    // Stage p1: registered responses, memory and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rr_ptr       <= 1'b0;
            rsp_vld_p1   <= '0;
            rsp_rdata_p1 <= '0;
            rsp_err_p1   <= '0;
        end else begin
            rsp_vld_p1 <= grant_p0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_rdata_p1[i*WIDTH +: WIDTH] <= grant_p0[i] ? rdata_p0 : '0;
                rsp_err_p1[i]                  <= grant_p0[i] & !in_range_p0;
            end
            if (hs_p0) begin
                rr_ptr <= !sel_p0;
                if (we_p0 && in_range_p0) begin
                    mem[idx_p0] <= wdata_p0;
                end
            end
        end
    end

    assign OUT_req_ready = grant_p0;
    assign OUT_rsp_valid = rsp_vld_p1;
    assign OUT_rsp_rdata = rsp_rdata_p1;
    assign OUT_rsp_err   = rsp_err_p1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a reference model predicts grants and pushes
// expected responses into per-requester queues that are popped when responses appear.
module tb_mem_arbiter;
    localparam int NUM_REQ = 2;
    localparam int DEPTH   = 16;
    localparam int WIDTH   = 8;
    localparam int ADDR_W  = 32;

    typedef struct packed {
        logic [WIDTH-1:0] rdata;
        logic             err;
    } rsp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        valid;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*WIDTH-1:0]  wdata;
    logic [NUM_REQ-1:0]        ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ*WIDTH-1:0]  rsp_rdata;
    logic [NUM_REQ-1:0]        rsp_err;

    rsp_t             q0[$];
    rsp_t             q1[$];
    logic [WIDTH-1:0] mdl_mem [DEPTH];
    logic             mdl_rr;
    logic [1:0]       last_ready;
    int               n_chk  = 0;
    int               n_fail = 0;

    mem_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_req_valid (valid),
        .IN_req_we    (we),
        .IN_req_addr  (addr),
        .IN_req_wdata (wdata),
        .OUT_req_ready(ready),
        .OUT_rsp_valid(rsp_valid),
        .OUT_rsp_rdata(rsp_rdata),
        .OUT_rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        valid[i] = v;
        we[i]    = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*WIDTH +: WIDTH]  = d;
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: check responses and grant just before the edge, then update the model.
    task automatic cycle();
        logic [1:0]        g;
        logic              has;
        rsp_t              e;
        rsp_t              n;
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            has = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            e = '0;
            if (has) e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(has));
            chk($sformatf("rsp_rdata[%0d]", i), 32'(rsp_rdata[i*WIDTH +: WIDTH]), 32'(e.rdata));
            chk($sformatf("rsp_err[%0d]", i), 32'(rsp_err[i]), 32'(e.err));
        end
        g = 2'b00;
        if (!rst) begin
            if (valid == 2'b11) g = mdl_rr ? 2'b10 : 2'b01;
            else g = valid;
        end
        last_ready = ready;
        chk("req_ready", 32'(ready), 32'(g));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i]) begin
                a = addr[i*ADDR_W +: ADDR_W];
                if (a < ADDR_W'(DEPTH)) begin
                    if (we[i]) begin
                        mdl_mem[a[3:0]] = wdata[i*WIDTH +: WIDTH];
                        n = '{rdata: 8'h00, err: 1'b0};
                    end else begin
                        n = '{rdata: mdl_mem[a[3:0]], err: 1'b0};
                    end
                end else begin
                    n = '{rdata: 8'h00, err: 1'b1};
                end
                if (i == 0) q0.push_back(n);
                else q1.push_back(n);
                mdl_rr = (i == 0);
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mdl_mem[k] = '0;
            mdl_rr = 1'b0;
            q0.delete();
            q1.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        mdl_rr = 1'b0;
        for (int k = 0; k < DEPTH; k++) mdl_mem[k] = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Write then read back through requester 0
        set_req(0, 1'b1, 1'b1, 32'd3, 8'hA5);
        cycle();
        set_req(0, 1'b1, 1'b0, 32'd3, 8'h00);
        cycle();
        idle();
        cycle();
        cycle();

        // Both requesters valid from reset: grants alternate starting with req0
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 32'd1, 8'h00);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("alternate", 32'(last_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        idle();
        cycle();

        // Out-of-range accesses from requester 1
        set_req(1, 1'b1, 1'b1, 32'd16, 8'hFF);
        cycle();
        set_req(1, 1'b1, 1'b0, 32'd0, 8'h00);
        cycle();
        set_req(1, 1'b1, 1'b0, 32'h0000_0010, 8'h00);
        cycle();
        set_req(1, 1'b1, 1'b0, 32'h1000_0003, 8'h00);
        cycle();
        set_req(1, 1'b1, 1'b0, 32'd3, 8'h00);
        cycle();
        idle();
        cycle();

        // Read-after-write across requesters
        set_req(0, 1'b1, 1'b1, 32'd15, 8'h3C);
        cycle();
        set_req(0, 1'b0, 1'b0, 32'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 32'd15, 8'h00);
        cycle();
        chk("raw_grant_req1", 32'(last_ready), 32'h2);
        idle();
        cycle();

        // Fill memory, then reset together with a pending write
        for (int k = 0; k < DEPTH; k++) begin
            set_req(0, 1'b1, 1'b1, 32'(k), 8'(8'h10 + k));
            cycle();
        end
        set_req(0, 1'b1, 1'b1, 32'd7, 8'hEE);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'd7, 8'h00);
        set_req(1, 1'b1, 1'b0, 32'd8, 8'h00);
        cycle();
        chk("post_reset_first_grant", 32'(last_ready), 32'h1);
        set_req(0, 1'b0, 1'b0, 32'd0, 8'h00);
        for (int k = 0; k < DEPTH; k++) begin
            set_req(1, 1'b1, 1'b0, 32'(k), 8'h00);
            cycle();
        end
        idle();
        cycle();

        // Only requester 1 valid with rr_ptr at 0: granted every cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b0, 32'(k), 8'h00);
            cycle();
            chk("solo_req1", 32'(last_ready), 32'h2);
        end
        idle();
        cycle();
        cycle();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
